// File: rtl/kbd_decoder_pkg.sv
// Purpose: shared FSM encoding, scan-code constants and byte classes for the PS/2 key decoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package kbd_decoder_pkg;

    // Byte-handling FSM: fetch (IDLE), pop strobe (ACK), classify/update (PROC).
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_PROC = 2'd2
    } state_t;

    // What a buffered scan-code byte means given the pending prefix flags.
    typedef enum logic [2:0] {
        BK_EXT     = 3'd0,   // E0 prefix
        BK_BRK     = 3'd1,   // F0 prefix
        BK_RELEASE = 3'd2,   // code following F0
        BK_REPEAT  = 3'd3,   // typematic repeat of the held key
        BK_PRESS   = 3'd4    // new make code
    } byte_kind_t;

    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_BRK     = 8'hF0;
    localparam logic [7:0] ASCII_NONE = 8'h00;

endpackage

// File: rtl/kbd_decoder_ascii.sv
// Purpose: scan-code set 2 make code to ASCII (lowercase letters, digits, space, enter).
// Latency: purely combinational.
// Backpressure: none.
module kbd_ascii
    import kbd_decoder_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    output logic [7:0] ascii
);

    // Table lookup; E0-prefixed keys (arrows, keypad enter, ...) have no ASCII here.
    always_comb begin
        ascii = ASCII_NONE;
        if (!ext) begin
            case (code)
                8'h1C: ascii = 8'h61; // a
                8'h32: ascii = 8'h62; // b
                8'h21: ascii = 8'h63; // c
                8'h23: ascii = 8'h64; // d
                8'h24: ascii = 8'h65; // e
                8'h2B: ascii = 8'h66; // f
                8'h34: ascii = 8'h67; // g
                8'h33: ascii = 8'h68; // h
                8'h43: ascii = 8'h69; // i
                8'h3B: ascii = 8'h6A; // j
                8'h42: ascii = 8'h6B; // k
                8'h4B: ascii = 8'h6C; // l
                8'h3A: ascii = 8'h6D; // m
                8'h31: ascii = 8'h6E; // n
                8'h44: ascii = 8'h6F; // o
                8'h4D: ascii = 8'h70; // p
                8'h15: ascii = 8'h71; // q
                8'h2D: ascii = 8'h72; // r
                8'h1B: ascii = 8'h73; // s
                8'h2C: ascii = 8'h74; // t
                8'h3C: ascii = 8'h75; // u
                8'h2A: ascii = 8'h76; // v
                8'h1D: ascii = 8'h77; // w
                8'h22: ascii = 8'h78; // x
                8'h35: ascii = 8'h79; // y
                8'h1A: ascii = 8'h7A; // z
                8'h45: ascii = 8'h30; // 0
                8'h16: ascii = 8'h31; // 1
                8'h1E: ascii = 8'h32; // 2
                8'h26: ascii = 8'h33; // 3
                8'h25: ascii = 8'h34; // 4
                8'h2E: ascii = 8'h35; // 5
                8'h36: ascii = 8'h36; // 6
                8'h3D: ascii = 8'h37; // 7
                8'h3E: ascii = 8'h38; // 8
                8'h46: ascii = 8'h39; // 9
                8'h29: ascii = 8'h20; // space
                8'h5A: ascii = 8'h0D; // enter
                default: ascii = ASCII_NONE;
            endcase
        end
    end

endmodule

// File: rtl/kbd_decoder.sv
// Purpose: pops scan-code bytes from the ps2_keyboard FIFO and tracks the held key, its ASCII and a press counter.
// Latency: 3 cycles per byte (fetch, pop, classify); key outputs update on the edge leaving PROC.
// Backpressure: a byte is only popped (single-cycle active-low strobe) after it has been latched; reset suppresses a pending pop.
module kbd_decoder
    import kbd_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ps2_byte,
    input  logic       ps2_ready,
    input  logic       ps2_overflow,
    output logic       ps2_nextdata_n,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic [7:0] key_ascii,
    output logic [7:0] press_count,
    output logic       ovf_seen
);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] byte_r;
    logic       ext_pend;
    logic       brk_pend;
    logic       same_key;
    byte_kind_t byte_kind;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: wait for data, then spend exactly one cycle in each of ACK and PROC.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (ps2_ready) state_nxt = ST_ACK;
            ST_ACK:  state_nxt = ST_PROC;
            ST_PROC: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Pop strobe is low only during ACK. Gating with rst means a reset arriving
    // in ACK withdraws the strobe before the FIFO clocks it, so the byte stays queued.
    assign ps2_nextdata_n = !((state == ST_ACK) && !rst);

    // Capture the FIFO head when leaving IDLE; it is stable through ACK/PROC.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_r <= 8'h00;
        end else if ((state == ST_IDLE) && ps2_ready) begin
            byte_r <= ps2_byte;
        end
    end

    // Classify the buffered byte against the prefix flags and the currently held key.
    always_comb begin
        same_key  = key_valid && (byte_r == key_code) && (ext_pend == key_ext);
        byte_kind = BK_PRESS;
        if (byte_r == SC_EXT) begin
            byte_kind = BK_EXT;
        end else if (byte_r == SC_BRK) begin
            byte_kind = BK_BRK;
        end else if (brk_pend) begin
            byte_kind = BK_RELEASE;
        end else if (same_key) begin
            byte_kind = BK_REPEAT;
        end
    end

    // Prefix flags: set by E0/F0, consumed by the first ordinary byte that follows.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (state == ST_PROC) begin
            case (byte_kind)
                BK_EXT: ext_pend <= 1'b1;
                BK_BRK: brk_pend <= 1'b1;
                default: begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
            endcase
        end
    end

    // Held-key state: a new press replaces the key (last key wins); only a
    // release of that exact key (code and extended flag) drops key_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_valid   <= 1'b0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            press_count <= 8'h00;
        end else if (state == ST_PROC) begin
            case (byte_kind)
                BK_RELEASE: begin
                    if (same_key) key_valid <= 1'b0;
                end
                BK_PRESS: begin
                    key_valid   <= 1'b1;
                    key_code    <= byte_r;
                    key_ext     <= ext_pend;
                    press_count <= press_count + 8'd1;   // wraps modulo 256
                end
                default: ;
            endcase
        end
    end

    // Sticky overflow flag; decoding is not affected by it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_seen <= 1'b0;
        end else if (ps2_overflow) begin
            ovf_seen <= 1'b1;
        end
    end

    kbd_ascii u_ascii (
        .code  (key_code),
        .ext   (key_ext),
        .ascii (key_ascii)
    );

endmodule

// File: tb/tb_kbd_decoder.sv
module tb_kbd_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ps2_byte;
    logic       ps2_ready;
    logic       ps2_overflow;
    logic       ps2_nextdata_n;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic [7:0] key_ascii;
    logic [7:0] press_count;
    logic       ovf_seen;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] fifo_q[$];
    time        pop_t[$];

    kbd_decoder dut (
        .clk            (clk),
        .rst            (rst),
        .ps2_byte       (ps2_byte),
        .ps2_ready      (ps2_ready),
        .ps2_overflow   (ps2_overflow),
        .ps2_nextdata_n (ps2_nextdata_n),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .key_ext        (key_ext),
        .key_ascii      (key_ascii),
        .press_count    (press_count),
        .ovf_seen       (ovf_seen)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present the FIFO head to the DUT.
    task automatic present_head();
        ps2_ready = (fifo_q.size() != 0);
        ps2_byte  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    // Model of the ps2_keyboard FIFO: pop on every cycle the strobe is low,
    // until empty, then let the last byte finish processing.
    task automatic drain();
        int cyc = 0;
        present_head();
        while (fifo_q.size() != 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!ps2_nextdata_n) begin
                fifo_q.delete(0);
                pop_t.push_back($time);
            end
            present_head();
        end
        check_eq("drain_timeout", fifo_q.size(), 0);
        repeat (3) begin
            @(negedge clk);
            if (!ps2_nextdata_n) pop_t.push_back($time);
        end
    endtask

    task automatic send(input logic [7:0] b);
        fifo_q.push_back(b);
        drain();
    endtask

    task automatic do_reset();
        fifo_q.delete();
        present_head();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        ps2_byte     = 8'h00;
        ps2_ready    = 1'b0;
        ps2_overflow = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_valid", 32'(key_valid), 0);
        check_eq("rst_code", 32'(key_code), 0);
        check_eq("rst_ext", 32'(key_ext), 0);
        check_eq("rst_ascii", 32'(key_ascii), 0);
        check_eq("rst_count", 32'(press_count), 0);
        check_eq("rst_ovf", 32'(ovf_seen), 0);
        check_eq("rst_pop_n", 32'(ps2_nextdata_n), 1);
        rst = 1'b0;
        @(negedge clk);

        // Press / release of 'a'
        send(8'h1C);
        check_eq("a_valid", 32'(key_valid), 1);
        check_eq("a_code", 32'(key_code), 32'h1C);
        check_eq("a_ascii", 32'(key_ascii), 32'h61);
        check_eq("a_count", 32'(press_count), 1);
        send(8'hF0);
        check_eq("a_brk_nochg", 32'(key_valid), 1);
        send(8'h1C);
        check_eq("a_rel_valid", 32'(key_valid), 0);
        check_eq("a_rel_count", 32'(press_count), 1);
        check_eq("a_rel_code", 32'(key_code), 32'h1C);

        // Typematic repeat
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(8'h1C);
            check_eq("rep_count", 32'(press_count), 1);
        end
        send(8'hF0);
        send(8'h1C);
        check_eq("rep_count_end", 32'(press_count), 1);
        check_eq("rep_valid_end", 32'(key_valid), 0);

        // Extended key: press E0 75, a plain 75 release must not match, then E0 F0 75
        do_reset();
        send(8'hE0);
        check_eq("ext_prefix_nochg", 32'(key_valid), 0);
        send(8'h75);
        check_eq("ext_valid", 32'(key_valid), 1);
        check_eq("ext_flag", 32'(key_ext), 1);
        check_eq("ext_code", 32'(key_code), 32'h75);
        check_eq("ext_ascii", 32'(key_ascii), 0);
        check_eq("ext_count", 32'(press_count), 1);
        send(8'hF0);
        send(8'h75);
        check_eq("ext_plain_rel_ignored", 32'(key_valid), 1);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        check_eq("ext_rel_valid", 32'(key_valid), 0);
        check_eq("ext_rel_count", 32'(press_count), 1);
        // Extended variant of a mapped code still has no ASCII
        send(8'hE0);
        send(8'h1C);
        check_eq("ext_a_ascii", 32'(key_ascii), 0);
        check_eq("ext_a_count", 32'(press_count), 2);

        // Last key wins
        do_reset();
        send(8'h1C);
        send(8'h32);
        check_eq("lkw_code", 32'(key_code), 32'h32);
        check_eq("lkw_ascii", 32'(key_ascii), 32'h62);
        check_eq("lkw_count", 32'(press_count), 2);
        send(8'hF0);
        send(8'h1C);
        check_eq("lkw_old_rel_valid", 32'(key_valid), 1);
        send(8'hF0);
        send(8'h32);
        check_eq("lkw_new_rel_valid", 32'(key_valid), 0);

        // ASCII table spot checks
        send(8'h45); check_eq("asc_0", 32'(key_ascii), 32'h30);
        send(8'h46); check_eq("asc_9", 32'(key_ascii), 32'h39);
        send(8'h29); check_eq("asc_space", 32'(key_ascii), 32'h20);
        send(8'h5A); check_eq("asc_enter", 32'(key_ascii), 32'h0D);
        send(8'h1A); check_eq("asc_z", 32'(key_ascii), 32'h7A);
        send(8'h76); check_eq("asc_unmapped", 32'(key_ascii), 0);
        check_eq("asc_count", 32'(press_count), 8);

        // 256 press/release pairs of '1': counter wraps to 0
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send(8'h16);
            if (i == 0) begin
                check_eq("wrap_first_ascii", 32'(key_ascii), 32'h31);
                check_eq("wrap_first_count", 32'(press_count), 1);
            end
            fifo_q.push_back(8'hF0);
            fifo_q.push_back(8'h16);
            drain();
            if (i == 254) check_eq("wrap_255", 32'(press_count), 32'hFF);
        end
        check_eq("wrap_count", 32'(press_count), 0);
        check_eq("wrap_valid", 32'(key_valid), 0);

        // Three queued bytes with ready held: one-cycle pops 3 cycles apart
        do_reset();
        pop_t.delete();
        fifo_q.push_back(8'h1C);
        fifo_q.push_back(8'hF0);
        fifo_q.push_back(8'h1C);
        drain();
        check_eq("pop_num", pop_t.size(), 3);
        if (pop_t.size() == 3) begin
            check_eq("pop_gap1", 32'(pop_t[1] - pop_t[0]), 30);
            check_eq("pop_gap2", 32'(pop_t[2] - pop_t[1]), 30);
        end
        check_eq("pop_seq_valid", 32'(key_valid), 0);
        check_eq("pop_seq_count", 32'(press_count), 1);

        // Overflow flag is sticky and does not disturb decoding
        check_eq("ovf_pre", 32'(ovf_seen), 0);
        ps2_overflow = 1'b1;
        @(negedge clk);
        ps2_overflow = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("ovf_set", 32'(ovf_seen), 1);
        send(8'h24);
        check_eq("ovf_decode", 32'(key_ascii), 32'h65);
        check_eq("ovf_still", 32'(ovf_seen), 1);
        do_reset();
        check_eq("ovf_cleared", 32'(ovf_seen), 0);

        // Reset during ACK of 0x1C: pop withdrawn, byte stays queued
        send(8'h29);
        fifo_q.push_back(8'h1C);
        present_head();
        @(negedge clk);
        check_eq("ack_pop_low", 32'(ps2_nextdata_n), 0);
        rst = 1'b1;
        #1;
        check_eq("ack_rst_pop_high", 32'(ps2_nextdata_n), 1);
        @(negedge clk);
        rst = 1'b0;
        check_eq("ack_rst_pop_next", 32'(ps2_nextdata_n), 1);
        check_eq("ack_rst_count", 32'(press_count), 0);
        check_eq("ack_rst_valid", 32'(key_valid), 0);
        check_eq("ack_rst_queued", fifo_q.size(), 1);
        drain();
        check_eq("ack_retry_code", 32'(key_code), 32'h1C);
        check_eq("ack_retry_count", 32'(press_count), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/kbd_decoder.md
KBD_DECODER -- requirements
Module: kbd_decoder

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-003 SHALL have port ps2_byte, input, 8, head-of-FIFO scan-code byte from ps2_keyboard.
REQ-004 SHALL have port ps2_ready, input, 1, ps2_keyboard FIFO non-empty.
REQ-005 SHALL have port ps2_overflow, input, 1, ps2_keyboard FIFO overflow indication.
REQ-006 SHALL have port ps2_nextdata_n, output, 1, active-low pop strobe to ps2_keyboard.
REQ-007 SHALL have port key_valid, output, 1, a key is currently held.
REQ-008 SHALL have port key_code, output, 8, make code of held or last key.
REQ-009 SHALL have port key_ext, output, 1, held or last key was E0-prefixed.
REQ-010 SHALL have port key_ascii, output, 8, ASCII of key_code; 0x00 if unmapped or key_ext=1.
REQ-011 SHALL have port press_count, output, 8, count of distinct key presses since reset.
REQ-012 SHALL have port ovf_seen, output, 1, sticky flag: ps2_overflow observed high.

Function
REQ-013 SHALL implement FSM states IDLE, ACK, PROC; each byte takes exactly 3 cycles.
REQ-014 IDLE: if ps2_ready=1, SHALL latch ps2_byte into byte_r and go to ACK; otherwise stay.
REQ-015 ACK: SHALL drive ps2_nextdata_n=0 for exactly this one cycle, then go to PROC; ps2_ready/ps2_byte ignored.
REQ-016 PROC: SHALL classify byte_r per REQ-017..021, then go to IDLE; ps2_nextdata_n=1 in all states except ACK.
REQ-017 byte_r=0xE0: SHALL set ext_pend=1; no output change.
REQ-018 byte_r=0xF0: SHALL set brk_pend=1; no output change.
REQ-019 Other byte, brk_pend=1 (release): if key_valid=1 and byte_r==key_code and ext_pend==key_ext, SHALL clear key_valid; otherwise no output change; then clear brk_pend and ext_pend.
REQ-020 Other byte, brk_pend=0, key_valid=1, byte_r==key_code, ext_pend==key_ext (typematic repeat): SHALL change no outputs; press_count unchanged; clear ext_pend.
REQ-021 Other byte, brk_pend=0, otherwise (new press): SHALL set key_valid=1, key_code=byte_r, key_ext=ext_pend, press_count+1; clear ext_pend.
REQ-022 press_count SHALL wrap 0xFF -> 0x00 modulo 256; no saturation.
REQ-023 A new press while another key is held SHALL replace key_code/key_ext (last-key-wins); releasing the replaced key SHALL not clear key_valid.
REQ-024 key_ascii SHALL be combinational from key_code/key_ext: 0x1C->0x61 'a' ... letters lowercase, 0x45/0x16..0x46 digits -> 0x30..0x39, 0x29->0x20, 0x5A->0x0D; all others 0x00.
REQ-025 ovf_seen SHALL set on any cycle with ps2_overflow=1 and stay set until reset; decoding continues unaffected.

Reset
REQ-026 rst=1 at an edge SHALL force state=IDLE, ps2_nextdata_n=1, key_valid=0, key_code=0x00, key_ext=0, press_count=0x00, ovf_seen=0, brk_pend=0, ext_pend=0, byte_r=0x00.
REQ-027 Reset during ACK or PROC SHALL abort that byte with no output update; the pop, if not yet clocked, is not issued.
REQ-028 key_ascii SHALL read 0x00 after reset (follows key_code=0x00).

Structure
REQ-029 Shared package SHALL hold FSM state encoding and constants SC_EXT=0xE0, SC_BRK=0xF0, ASCII_NONE=0x00.
REQ-030 Scan-code-to-ASCII table SHALL be a separate combinational sub-module kbd_ascii (in code[7:0], ext, out ascii[7:0]).
REQ-031 Outputs key_code, key_ascii, press_count SHALL be sized to feed the seg driver directly (two hex digits each).

Verification
REQ-032 Bytes 1C, F0, 1C -> after byte 1: key_valid=1, key_code=0x1C, key_ascii=0x61, press_count=1; after byte 3: key_valid=0, press_count=1.
REQ-033 Bytes 1C,1C,1C,1C (typematic), F0,1C -> press_count=1 throughout; key_valid=0 at end.
REQ-034 Bytes E0,75 then E0,F0,75 -> key_ext=1, key_code=0x75, key_ascii=0x00, count+1; then key_valid=0.
REQ-035 256 press/release pairs of 0x16 -> press_count=0x00 after the 256th; 0x16 maps to 0x31.
REQ-036 ps2_ready held high with 3 queued bytes -> ps2_nextdata_n low exactly 3 single cycles, 3 cycles apart; ps2_overflow pulse -> ovf_seen=1 until rst.
REQ-037 rst asserted in ACK of byte 0x1C -> ps2_nextdata_n=1 next cycle, press_count=0, key_valid=0, byte not consumed.
